// File: rtl/fdd_track_sequencer.sv
// Floppy drive-side engine: head positioning, rotational word timing,
// and track-image RAM sequencing for the PPU floppy register block.
module fdd_track_sequencer #(
  parameter int          WORD_DIV    = 1600,
  parameter int          TRACK_WORDS = 3125,
  parameter int          IND_WORDS   = 8,
  parameter int          MAX_CYL     = 80,
  parameter int          STEP_SETTLE = 50000,
  parameter logic [15:0] SYNC_WORD   = 16'hA1A1,
  parameter logic [15:0] CRC_INIT    = 16'hFFFF
) (
  input  logic        ppu_vm_clk_p,
  input  logic        ppu_vm_init_i,
  input  logic [1:0]  drive,
  input  logic        motor,
  input  logic        step,
  input  logic        dir,
  input  logic        head,
  input  logic [15:0] data_out,
  input  logic        write,
  input  logic [3:0]  img_present,
  output logic [15:0] data_in,
  output logic        valid,
  output logic        sync,
  output logic        crc_ok,
  output logic        rdy,
  output logic        tr0,
  output logic        ind,
  output logic [21:0] trk_adr,
  output logic        trk_rd,
  output logic        trk_we,
  output logic [15:0] trk_dat_o,
  input  logic [15:0] trk_dat_i,
  input  logic        trk_ack
);

  localparam int TW = (WORD_DIV > 1) ? $clog2(WORD_DIV) : 1;
  localparam int SW = $clog2(STEP_SETTLE + 1);
  localparam logic [TW-1:0] T_END   = TW'(WORD_DIV - 1);
  localparam logic [11:0]   W_END   = 12'(TRACK_WORDS - 1);
  localparam logic [11:0]   W_IND   = 12'(IND_WORDS);
  localparam logic [6:0]    CYL_TOP = 7'(MAX_CYL - 1);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    PRESENT
  } state_t;

  state_t state, state_n;

  logic [6:0]    cyl [4];
  logic [11:0]   widx;
  logic [11:0]   widx_nx;
  logic [TW-1:0] timer;
  logic [SW-1:0] settle;
  logic [1:0]    drive_q;
  logic [21:0]   adr_q;
  logic [15:0]   wr_word;
  logic [15:0]   crc;
  logic [15:0]   crc_n;
  logic [6:0]    cur_cyl;
  logic          step_q;
  logic          spin_q;
  logic          seen;
  logic          abort_q;
  logic          fetch_wr;
  logic          wr_pend;
  logic          spin;
  logic          lose;
  logic          tick;
  logic          step_rise;
  logic          rd_done;

  function automatic logic [15:0] crc16(
    input logic [15:0] c,
    input logic [15:0] d
  );
    logic [15:0] r;
    logic        fb;
    r = c;
    for (int i = 15; i >= 0; i--) begin
      fb = r[15] ^ d[i];
      r  = {r[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end
    return r;
  endfunction

  assign spin      = motor & img_present[drive];
  assign lose      = (spin_q & ~spin) | (drive != drive_q);
  assign tick      = (state == IDLE) & spin & (timer == T_END);
  assign widx_nx   = (widx == W_END) ? 12'd0 : widx + 12'd1;
  assign step_rise = step & ~step_q;
  assign cur_cyl   = cyl[drive];
  assign rd_done   = (state == FETCH) & trk_ack & ~fetch_wr
                   & ~abort_q & ~lose;

  // Sync word restarts the CRC from its preset
  assign crc_n = crc16((trk_dat_i == SYNC_WORD) ? CRC_INIT : crc,
                       trk_dat_i);

  assign tr0     = (cur_cyl == 7'd0);
  assign rdy     = spin & seen & (settle == '0);
  assign ind     = spin & (widx < W_IND);
  assign trk_adr = adr_q;

  always_ff @(posedge ppu_vm_clk_p) begin
    if (ppu_vm_init_i) state <= IDLE;
    else               state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (tick) state_n = FETCH;
      FETCH: begin
        if (trk_ack) begin
          if (fetch_wr | abort_q | lose) state_n = IDLE;
          else                           state_n = PRESENT;
        end
      end
      PRESENT: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    trk_rd = (state == FETCH) & ~fetch_wr;
    trk_we = (state == FETCH) & fetch_wr;
    valid  = (state == PRESENT);
    sync   = (state == PRESENT) & (data_in == SYNC_WORD);
  end

  always_ff @(posedge ppu_vm_clk_p) begin
    if (ppu_vm_init_i) begin
      for (int i = 0; i < 4; i++) cyl[i] <= '0;
      widx      <= '0;
      timer     <= '0;
      settle    <= '0;
      step_q    <= 1'b0;
      spin_q    <= 1'b0;
      drive_q   <= '0;
      seen      <= 1'b0;
      abort_q   <= 1'b0;
      fetch_wr  <= 1'b0;
      wr_pend   <= 1'b0;
      wr_word   <= '0;
      adr_q     <= '0;
      trk_dat_o <= '0;
      data_in   <= '0;
      crc       <= CRC_INIT;
      crc_ok    <= 1'b0;
    end else begin
      step_q  <= step;
      spin_q  <= spin;
      drive_q <= drive;

      if (step_rise) begin
        settle <= SW'(STEP_SETTLE);
        if (dir) begin
          if (cur_cyl != CYL_TOP) cyl[drive] <= cur_cyl + 7'd1;
        end else begin
          if (cur_cyl != 7'd0) cyl[drive] <= cur_cyl - 7'd1;
        end
      end else if (settle != '0) begin
        settle <= settle - SW'(1);
      end

      if (lose)                      seen <= 1'b0;
      else if (tick && widx_nx == 0) seen <= 1'b1;

      if (!spin || state != IDLE || tick) timer <= '0;
      else                                timer <= timer + TW'(1);

      // Address and direction are frozen for the whole RAM access
      if (tick) begin
        widx      <= widx_nx;
        adr_q     <= {drive, cur_cyl, head, widx_nx};
        fetch_wr  <= wr_pend | write;
        trk_dat_o <= write ? data_out : wr_word;
        abort_q   <= 1'b0;
      end else if (state == FETCH && lose) begin
        abort_q <= 1'b0 | 1'b1;
      end

      if (write) begin
        wr_pend <= 1'b1;
        wr_word <= data_out;
      end else if (state == FETCH && trk_ack && fetch_wr) begin
        wr_pend <= 1'b0;
      end

      if (rd_done) begin
        data_in <= trk_dat_i;
        crc     <= crc_n;
        crc_ok  <= (crc_n == 16'h0000);
      end
    end
  end

endmodule

// File: doc/fdd_track_sequencer.md
Name: fdd_track_sequencer

Overview:
- Drive-side engine behind the PPU floppy register block (ports 177130/177132).
- Takes the motor, step, direction, head and drive-select lines plus the CPU write stream.
- Keeps per-drive cylinder position and rotational word position, and sequences the track-image RAM (read/write) at the disk word rate.
- Returns data_in, valid, sync, crc_ok, rdy, tr0 and ind to the register block.

Parameters:
WORD_DIV, 1600, clocks per 16-bit disk word slot (min 8)
TRACK_WORDS, 3125, words per track revolution
IND_WORDS, 8, words at start of revolution during which ind is high
MAX_CYL, 80, number of cylinders; valid positions are 0..MAX_CYL-1
STEP_SETTLE, 50000, clocks rdy is held low after each step
SYNC_WORD, 16'hA1A1, marker word that raises sync
CRC_INIT, 16'hFFFF, CRC-CCITT preset applied before the sync word

Ports:
ppu_vm_clk_p  in  1  system clock
ppu_vm_init_i  in  1  reset, synchronous, active-high
drive  in  2  selected drive index
motor  in  1  spindle enable
step  in  1  step strobe, acts on rising edge
dir  in  1  1 = inward (cylinder+1), 0 = outward
head  in  1  side select
data_out  in  16  CPU word to write
write  in  1  one-cycle write strobe accompanying data_out
img_present  in  4  disk image loaded, one bit per drive
data_in  out  16  last word read from the track
valid  out  1  one-cycle pulse: data_in updated
sync  out  1  one-cycle pulse coincident with valid when data_in == SYNC_WORD
crc_ok  out  1  running CRC == 0 after the last presented word
rdy  out  1  drive ready
tr0  out  1  selected drive at cylinder 0
ind  out  1  index window
trk_adr  out  22  {drive[1:0], cyl[6:0], head, widx[11:0]}
trk_rd  out  1  RAM read request, held until trk_ack
trk_we  out  1  RAM write request, held until trk_ack
trk_dat_o  out  16  RAM write data
trk_dat_i  in  16  RAM read data
trk_ack  in  1  RAM handshake completion, one cycle

Behaviour:
- Reset (synchronous, ppu_vm_init_i high at clock edge):
  - All four cylinders = 0; widx = 0; timer = 0; FSM = IDLE; crc = CRC_INIT.
  - data_in = 0; valid, sync, crc_ok, rdy, ind, trk_rd, trk_we = 0; trk_dat_o = 0.
  - Reset dominates every other event, including an outstanding RAM request; trk_rd and trk_we are low the cycle after.
- spin = motor & img_present[drive].
- tr0 = (cyl[drive] == 0), combinational, independent of motor.
- Step:
  - Rising edge of step (registered previous value) acts on cyl[drive].
  - dir=1: +1, saturating at MAX_CYL-1. dir=0: -1, saturating at 0.
  - Every step edge, including a saturated one, loads the settle counter with STEP_SETTLE.
  - A step during a RAM transaction changes cyl immediately; the in-flight access completes at the address latched at request time.
- rdy = spin & seen_index & (settle == 0).
  - seen_index clears when spin falls or drive changes.
  - seen_index sets at the first widx wrap to 0 while spin is high.
- Word timer:
  - Counts only in IDLE with spin high.
  - At count WORD_DIV-1: reset to 0, advance widx (TRACK_WORDS-1 wraps to 0), go to FETCH.
  - ind = spin & (widx < IND_WORDS).
- FSM:
  - IDLE -> FETCH at timer terminal.
  - FETCH: trk_adr latched.
    - If wr_pend: assert trk_we with trk_dat_o = wr_word; on trk_ack clear wr_pend and go to IDLE (no valid).
    - Else: assert trk_rd; on trk_ack go to PRESENT.
  - PRESENT (1 cycle): data_in <= trk_dat_i; valid = 1; sync = (trk_dat_i == SYNC_WORD); update crc; go to IDLE.
- Write latch:
  - A write pulse sets wr_pend and wr_word = data_out.
  - A second write before consumption overwrites wr_word (last wins).
  - A write pulse in the same cycle wr_pend clears re-sets it.
- CRC:
  - CRC-CCITT, poly 0x1021, MSB first, 16 bits per word.
  - Sync word: crc <= f(CRC_INIT, word). Other presented words: crc <= f(crc, word).
  - crc_ok updates in the same cycle as valid and holds until the next presented word.
- Abort: spin falling or a drive change while in FETCH:
  - The request is held until trk_ack; no valid is issued; the FSM returns to IDLE.
  - widx is retained; the timer restarts from 0.
- Late RAM: the timer does not run outside IDLE, so a slow trk_ack stretches that slot; no words are skipped.

Test Plan:
- Reset: assert ppu_vm_init_i mid-FETCH (trk_rd=1) -> next cycle trk_rd=0, tr0=1, rdy=0, data_in=0, widx=0.
- Stepping: 85 inward steps then 3 outward, drive=1 -> cyl[1]=79 then 76; tr0=0; rdy low for STEP_SETTLE clocks after the last edge; cyl[0] still 0.
- Streaming (WORD_DIV=8, TRACK_WORDS=16, zero-latency ack): RAM word = widx -> valid every 10 clocks with data_in 1,2,..15,0; ind high for widx 0..7; rdy rises after the first wrap.
- Sync/CRC: track holds A1A1, 1234, then that pair's correct CRC word -> sync only on the first word; crc_ok=0 after 1234, 1 after the CRC word.
- Write-back: write pulses with data_out=BEEF then CAFE inside one slot -> next slot issues trk_we, trk_dat_o=CAFE at the current widx address, no valid that slot.
- Abort: drop motor while trk_rd is pending, ack after 5 clocks -> no valid, FSM IDLE, rdy=0, widx unchanged.
